// File: rtl/nrn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nrn_pkg
// Description : Shared datapath types for the LIF neuron layer.
//               Words are sign-magnitude: bit N-1 is the sign and bits
//               N-2:0 hold a Q32 magnitude. The package also holds the
//               scheduler state encoding and the negative-zero fix used
//               whenever a membrane is written back.
// Revision    : 1.0 - initial release
// ============================================================================
package nrn_pkg;

    localparam int N = 35;
    localparam int Q = 32;

    typedef logic [N-1:0] fxp_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FETCH = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } sched_state_e;

    // Sign-magnitude has two encodings of zero; only the positive one is
    // ever stored so that later equality compares stay simple.
    function automatic fxp_t fxp_norm(input fxp_t x);
        fxp_t r;
        r = x;
        if (x[N-2:0] == '0) begin
            r[N-1] = 1'b0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nrn_mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : nrn_mem_bank
// Description : Flop-based 1R1W membrane store. Asynchronous read,
//               synchronous write. i_clr writes zero to entry i_waddr so a
//               caller can sweep the bank one entry per cycle; rst zeroes
//               every entry at once.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_we, i_clr    - write enable / zero-write enable
//               i_waddr        - write address
//               i_wdata        - write data
//               i_raddr        - read address
//               o_rdata        - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module nrn_mem_bank #(
    parameter int DEPTH = 16,
    parameter int W     = 35,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic          i_clr,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clr) begin
            r_mem[i_waddr] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/nrn_layer_sched.sv
`default_nettype none
// ============================================================================
// Module      : nrn_layer_sched
// Description : Time-multiplexes one LIF neuron core across NUM_NRN logical
//               neurons. Each timestep walks the neurons in index order:
//               fetch current, present membrane+current to the core with a
//               level flag, write back the returned membrane and collect
//               the spike bit.
// Ports       : clock, reset        - clock, synchronous active-high reset
//               start, clear        - timestep start / membrane clear (IDLE)
//               busy, done          - status, one-cycle end-of-step pulse
//               err_timeout         - sticky core timeout flag
//               cur_addr, cur_data  - current buffer (1-cycle read latency)
//               nrn_flag, nrn_vmem, nrn_in      - core request side
//               nrn_mem_out, nrn_out, nrn_flag_out - core response side
//               spikes, spike_cnt   - result of last completed timestep
// Revision    : 1.0 - initial release
// ============================================================================
module nrn_layer_sched #(
    parameter int N       = nrn_pkg::N,
    parameter int NUM_NRN = 16,
    parameter int TIMEOUT = 15,
    parameter int AW      = $clog2(NUM_NRN)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic [AW-1:0]      cur_addr,
    input  logic [N-1:0]       cur_data,
    output logic               nrn_flag,
    output logic [N-1:0]       nrn_vmem,
    output logic [N-1:0]       nrn_in,
    input  logic [N-1:0]       nrn_mem_out,
    input  logic [N-1:0]       nrn_out,
    input  logic               nrn_flag_out,
    output logic [NUM_NRN-1:0] spikes,
    output logic [AW:0]        spike_cnt
);

    import nrn_pkg::*;

    localparam int          c_TW   = $clog2(TIMEOUT + 1);
    localparam int          c_CW   = AW + 1;
    localparam logic [AW-1:0]   c_LAST = AW'(NUM_NRN - 1);
    localparam logic [c_TW-1:0] c_TO   = c_TW'(TIMEOUT);

    sched_state_e        r_state;
    sched_state_e        w_next;
    logic [AW-1:0]       r_idx;
    logic [c_TW-1:0]     r_wcnt;
    logic                r_to;
    logic                r_err;
    logic [N-1:0]        r_vmem;
    logic [N-1:0]        r_in;
    logic [NUM_NRN-1:0]  r_work;
    logic [NUM_NRN-1:0]  r_spikes;
    logic [c_CW-1:0]     r_cnt;
    logic [c_CW-1:0]     w_pop;
    logic [N-1:0]        w_mem_rd;
    logic [N-1:0]        w_mem_wdata;
    logic                w_mem_we;
    logic                w_mem_clr;
    logic                w_unused_nrn_out;

    // Only the spike bit of the core output is meaningful here.
    assign w_unused_nrn_out = &{1'b0, nrn_out[N-1:1]};

    nrn_mem_bank #(
        .DEPTH (NUM_NRN),
        .W     (N),
        .AW    (AW)
    ) u_mem (
        .clk     (clock),
        .rst     (reset),
        .i_we    (w_mem_we),
        .i_clr   (w_mem_clr),
        .i_waddr (r_idx),
        .i_wdata (w_mem_wdata),
        .i_raddr (r_idx),
        .o_rdata (w_mem_rd)
    );

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        nrn_flag    = 1'b0;
        w_mem_clr   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_wdata = fxp_norm(nrn_mem_out);
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_next = S_CLR;
                end else if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_CLR: begin
                w_mem_clr = 1'b1;
                if (r_idx == c_LAST) begin
                    w_next = S_IDLE;
                end
            end
            S_FETCH: w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                nrn_flag = 1'b1;
                if (nrn_flag_out || (r_wcnt == c_TO)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                // A timed-out neuron keeps its previous membrane.
                w_mem_we = ~r_to;
                w_next   = (r_idx == c_LAST) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_NRN; i++) begin
            w_pop = w_pop + c_CW'(r_work[i]);
        end
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_wcnt   <= '0;
            r_to     <= 1'b0;
            r_err    <= 1'b0;
            r_vmem   <= '0;
            r_in     <= '0;
            r_work   <= '0;
            r_spikes <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (start && !clear) begin
                        r_work <= '0;
                    end
                end
                S_CLR: begin
                    r_err <= 1'b0;
                    r_idx <= (r_idx == c_LAST) ? '0 : r_idx + AW'(1);
                end
                S_FETCH: begin
                    r_wcnt <= '0;
                    r_to   <= 1'b0;
                end
                S_ISSUE: begin
                    r_in   <= cur_data;
                    r_vmem <= w_mem_rd;
                end
                S_WAIT: begin
                    if (!nrn_flag_out) begin
                        r_wcnt <= r_wcnt + c_TW'(1);
                        if (r_wcnt == c_TO) begin
                            r_to  <= 1'b1;
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_work[r_idx] <= r_to ? 1'b0 : nrn_out[0];
                    r_idx         <= (r_idx == c_LAST) ? '0 : r_idx + AW'(1);
                end
                S_DONE: begin
                    r_spikes <= r_work;
                    r_cnt    <= w_pop;
                end
                default: ;
            endcase
        end
    end

    assign cur_addr    = r_idx;
    assign nrn_vmem    = r_vmem;
    assign nrn_in      = r_in;
    assign err_timeout = r_err;
    assign spikes      = r_spikes;
    assign spike_cnt   = r_cnt;

endmodule
`default_nettype wire
